// File: rtl/cpu4_core.sv
// rtl/cpu4_core.sv - 4-bit three-phase CPU core with 16x4 data RAM
//
// Purpose: executes one 11-bit instruction {opcode[10:8], dest[7:4], src_val[3:0]}
//          every three clocks. The three phases are FETCH, EXEC and STORE.
//          Each instruction reads RAM[dest], combines it with src_val in the ALU,
//          and writes the result back to RAM[dest].
// Optional feature: define CPU_ZERO_FLAG_EN to add the debug_zero output.
//
// cpu4_ram ports:
//   clk, rst        clock, synchronous active-high clear of all words
//   we, waddr, wdata write port
//   raddr, rdata     asynchronous read port
//
// cpu4_core ports:
//   clk              system clock, rising edge
//   reset_n          synchronous reset, active-high despite the name
//   instruction[10:0] instruction, sampled only on the FETCH edge
//   debug_alu_res    registered ALU result of the last EXEC
//   debug_ram_out    registered RAM operand captured at FETCH
//   debug_cout       registered carry / no-borrow flag of the last EXEC
//   debug_zero       (CPU_ZERO_FLAG_EN only) registered result==0 flag

module cpu4_ram #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   // Reset has priority so a write pending on the reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

module cpu4_core #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [10:0]       instruction,
   output logic [DATA_W-1:0] debug_alu_res,
   output logic [DATA_W-1:0] debug_ram_out,
`ifdef CPU_ZERO_FLAG_EN
   output logic              debug_cout,
   output logic              debug_zero
`else
   output logic              debug_cout
`endif
);
   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_STORE} state_t;

   localparam logic [2:0] OP_STO = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                          OP_OR  = 3'd4, OP_XOR = 3'd5, OP_NOT = 3'd6, OP_NOP = 3'd7;

   state_t            state_q, state_d;
   logic [10:0]       ir_q, ir_d;
   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              cout_q, cout_d;
   logic              zero_q, zero_d;

   logic [DATA_W-1:0] ram_rdata;
   logic              ram_we;
   logic [DATA_W-1:0] alu_res;
   logic              alu_cout;
   logic [DATA_W:0]   sum_w;
   logic [DATA_W:0]   diff_w;

   wire [2:0]        ir_op   = ir_q[10:8];
   wire [ADDR_W-1:0] ir_dest = ir_q[7:4];
   wire [DATA_W-1:0] ir_src  = ir_q[3:0];

   // The read address comes straight from the external instruction so the
   // operand can be captured on the same FETCH edge as the IR.
   cpu4_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst   (reset_n),
      .we    (ram_we),
      .waddr (ir_dest),
      .wdata (res_q),
      .raddr (instruction[7:4]),
      .rdata (ram_rdata)
   );

   assign ram_we = (state_q == S_STORE) && (ir_op != OP_NOP);

   // The subtraction is computed as a + ~b + 1, so the carry out means no borrow.
   always_comb begin
      sum_w    = {1'b0, opnd_q} + {1'b0, ir_src};
      diff_w   = {1'b0, opnd_q} + {1'b0, ~ir_src} + {{DATA_W{1'b0}}, 1'b1};
      alu_res  = '0;
      alu_cout = 1'b0;
      case (ir_op)
         OP_STO: alu_res = ir_src;
         OP_ADD: begin alu_res = sum_w[DATA_W-1:0];  alu_cout = sum_w[DATA_W];  end
         OP_SUB: begin alu_res = diff_w[DATA_W-1:0]; alu_cout = diff_w[DATA_W]; end
         OP_AND: alu_res = opnd_q & ir_src;
         OP_OR:  alu_res = opnd_q | ir_src;
         OP_XOR: alu_res = opnd_q ^ ir_src;
         OP_NOT: alu_res = ~opnd_q;
         default: alu_res = res_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      case (state_q)
         S_FETCH: begin
            ir_d    = instruction;
            opnd_d  = ram_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            // NOP leaves the result and flags untouched.
            if (ir_op != OP_NOP) begin
               res_d  = alu_res;
               cout_d = alu_cout;
               zero_d = (alu_res == '0);
            end
            state_d = S_STORE;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
      end
   end

   assign debug_alu_res = res_q;
   assign debug_ram_out = opnd_q;
   assign debug_cout    = cout_q;
`ifdef CPU_ZERO_FLAG_EN
   assign debug_zero    = zero_q;
`else
   logic unused_zero;
   assign unused_zero = zero_q;
`endif
endmodule

// File: tb/tb_cpu4_core.sv
// tb/tb_cpu4_core.sv - self-checking bench for cpu4_core
module tb_cpu4_core;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] instruction;
   logic [3:0]  debug_alu_res;
   logic [3:0]  debug_ram_out;
   logic        debug_cout;
`ifdef CPU_ZERO_FLAG_EN
   logic        debug_zero;
`endif

   cpu4_core dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .instruction   (instruction),
      .debug_alu_res (debug_alu_res),
      .debug_ram_out (debug_ram_out),
`ifdef CPU_ZERO_FLAG_EN
      .debug_cout    (debug_cout),
      .debug_zero    (debug_zero)
`else
      .debug_cout    (debug_cout)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [3:0] d;
      logic [3:0] v;
      logic [3:0] exp_res;
      logic       exp_cout;
   } vec_t;

   typedef struct {
      logic [3:0] res;
      logic       cout;
      logic       wr;
      logic [3:0] addr;
   } exp_t;

   vec_t       vecs[14];
   exp_t       sb[$];
   logic [3:0] model_mem[16];
   int         nvec = 0;
   int         nerr = 0;

   task automatic chk(input string name, input int act, input int req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_res"}, debug_alu_res, 0);
      chk({tag, "_cout"}, debug_cout, 0);
      chk({tag, "_ramout"}, debug_ram_out, 0);
`ifdef CPU_ZERO_FLAG_EN
      chk({tag, "_zero"}, debug_zero, 0);
`endif
      for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), dut.u_ram.mem[i], 0);
   endtask

   // Runs one instruction from a FETCH boundary. The expected result comes from the table.
   // The expected operand comes from the bench RAM model.
   task automatic run_vec(input vec_t v);
      exp_t e;
      logic [3:0] exp_opnd;
      exp_opnd = model_mem[v.d];
      e.res = v.exp_res; e.cout = v.exp_cout; e.wr = (v.op != 3'd7); e.addr = v.d;
      sb.push_back(e);
      instruction = {v.op, v.d, v.v};
      @(posedge clk); #1;
      chk($sformatf("ramout_op%0d_d%0h", v.op, v.d), debug_ram_out, exp_opnd);
      instruction = $urandom_range(0, 2047);
      @(posedge clk); #1;
      instruction = $urandom_range(0, 2047);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk($sformatf("res_op%0d_d%0h_v%0h", v.op, v.d, v.v), debug_alu_res, e.res);
         chk($sformatf("cout_op%0d_d%0h_v%0h", v.op, v.d, v.v), debug_cout, e.cout);
`ifdef CPU_ZERO_FLAG_EN
         chk($sformatf("zero_op%0d_d%0h", v.op, v.d), debug_zero, e.res == 4'h0);
`endif
         if (e.wr) model_mem[e.addr] = e.res;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++)
         chk($sformatf("mem%0d_after_op%0d", i, v.op), dut.u_ram.mem[i], model_mem[i]);
   endtask

   initial begin
      vecs[0]  = '{3'd0, 4'h4, 4'h5, 4'h5, 1'b0}; // STO
      vecs[1]  = '{3'd1, 4'h4, 4'h6, 4'hB, 1'b0}; // ADD
      vecs[2]  = '{3'd1, 4'h4, 4'h9, 4'h4, 1'b1}; // ADD wraps
      vecs[3]  = '{3'd0, 4'h1, 4'hF, 4'hF, 1'b0}; // STO
      vecs[4]  = '{3'd2, 4'h1, 4'h7, 4'h8, 1'b1}; // SUB no borrow
      vecs[5]  = '{3'd2, 4'h1, 4'h9, 4'hF, 1'b0}; // SUB borrow
      vecs[6]  = '{3'd6, 4'hF, 4'h3, 4'hF, 1'b0}; // NOT of 0
      vecs[7]  = '{3'd3, 4'h4, 4'h3, 4'h0, 1'b0}; // AND 4&3
      vecs[8]  = '{3'd4, 4'h4, 4'h3, 4'h3, 1'b0}; // OR  0|3
      vecs[9]  = '{3'd5, 4'h4, 4'h6, 4'h5, 1'b0}; // XOR 3^6
      vecs[10] = '{3'd1, 4'h2, 4'h7, 4'h7, 1'b0}; // ADD
      vecs[11] = '{3'd7, 4'h2, 4'h1, 4'h7, 1'b0}; // NOP holds
      vecs[12] = '{3'd2, 4'h2, 4'h7, 4'h0, 1'b1}; // SUB equal -> 0
      vecs[13] = '{3'd6, 4'h4, 4'h0, 4'hA, 1'b0}; // NOT 5

      for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
      instruction = 11'h0;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);

      // Reset during EXEC of an ADD aborts it and clears everything.
      instruction = {3'd1, 4'h4, 4'h1};
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      chk_all_zero("midreset");
      for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
      sb.delete();

      // After the reset the FSM starts in FETCH, so the normal timing applies.
      run_vec('{3'd1, 4'h4, 4'h3, 4'h3, 1'b0});
      run_vec('{3'd1, 4'h4, 4'hD, 4'h0, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/cpu4_core.md
Name: cpu4_core

Overview:
- Minimal 4-bit accumulator-less CPU core; executes one externally supplied 11-bit instruction every 3 clocks via a FETCH -> EXEC -> STORE state machine.
- Each instruction reads a 16x4 data RAM location, combines it with a 4-bit immediate in the ALU, and writes the result back to the same location.
- Top-level of the CPU; the instruction is supplied by the testbench or an external sequencer, with debug outputs exposed for bring-up.

Parameters:
- DATA_W, 4, ALU/RAM data width.
- ADDR_W, 4, RAM address width; RAM depth = 2**ADDR_W (16).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  synchronous reset, active-high (asserted when 1) despite the name; sampled on rising clk.
- instruction  input  11  {opcode[10:8], dest_addr[7:4], src_val[3:0]}; must be stable from the FETCH edge.
- debug_alu_res  output  4  registered ALU result of the last EXEC.
- debug_ram_out  output  4  registered operand read from RAM[dest_addr] during FETCH.
- debug_cout  output  1  registered carry/no-borrow flag of the last EXEC.

Behaviour:
- Opcodes:
  - 000 STO: res = src_val, cout = 0.
  - 001 ADD: res = RAM[d] + src_val, cout = carry out of bit 3.
  - 010 SUB: res = RAM[d] - src_val computed as RAM[d] + ~src_val + 1, cout = carry out (1 = no borrow).
  - 011 AND, 100 OR, 101 XOR: bitwise RAM[d] op src_val, cout = 0.
  - 110 NOT: res = ~RAM[d], src_val ignored, cout = 0.
  - 111 NOP: no RAM write; res and cout unchanged.
- FSM states FETCH -> EXEC -> STORE -> FETCH, one cycle each. No stalls, no handshake.
- FETCH edge:
  - latch instruction into an internal IR.
  - latch RAM[dest_addr] into the operand register, which drives debug_ram_out.
- EXEC edge: compute the ALU from IR and the operand; register res into debug_alu_res and cout into debug_cout.
- STORE edge: RAM[IR.dest] <= registered res, except for NOP.
- Latency: instruction present before FETCH edge -> ALU result visible 1 ns after the 2nd rising edge -> RAM updated after the 3rd edge.
- The external instruction is ignored outside FETCH; changes during EXEC/STORE have no effect.
- All 4-bit arithmetic wraps modulo 16.
- Reset (synchronous, reset_n=1 at a rising edge):
  - state = FETCH.
  - IR, operand, debug_alu_res, debug_cout, debug_ram_out = 0.
  - all 16 RAM words = 0.
- Reset mid-instruction aborts it; no RAM write occurs on that edge.
- Read-after-write: an instruction whose FETCH follows a STORE to the same address sees the new value, since STORE and FETCH are on different edges.
- RAM is a separate submodule instantiated as u_ram with storage array mem[0:15], for hierarchical checking by verification.

Optional Feature:
- Macro CPU_ZERO_FLAG_EN.
- Defined: extra output port debug_zero (1 bit), registered at EXEC as (res == 0), cleared on reset, held for NOP.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset 2 cycles, then instruction STO d=4 v=5 -> after 2 edges debug_alu_res=5, cout=0; after 3rd edge u_ram.mem[4]=5.
- ADD d=4 v=6 (RAM[4]=5) -> debug_alu_res=B, cout=0, mem[4]=B; ADD d=4 v=9 afterwards -> res=4, cout=1 (wrap).
- STO d=1 v=F, then SUB d=1 v=7 -> res=8, cout=1, mem[1]=8; SUB d=1 v=9 -> res=F, cout=0 (borrow).
- NOT d=F on reset RAM -> res=F, cout=0, mem[15]=F; AND/OR/XOR of mem[4] with 3 give expected bitwise values.
- Assert reset_n=1 during EXEC of an ADD -> no RAM write; all RAM words and debug outputs read 0 next cycle; FSM restarts in FETCH.
- NOP after ADD -> debug_alu_res/cout unchanged, RAM unchanged; with CPU_ZERO_FLAG_EN, SUB d=x of equal value -> debug_zero=1.
